// File: rtl/mem_access_sequencer.sv
// Memory access sequencer: turns one accepted request into a
// SETUP / STROBE / HOLD access on a split (upper/lower) 16-bit SRAM pair,
// then reports completion for one HOLD cycle.
// Optional feature: define MEM_SEQ_ERR_CNT_EN to add the saturating err_cnt
// output that counts reads completed with a non-zero decoder flag.
module mem_access_sequencer #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       wdata_up,
    input  logic [15:0]       wdata_down,
    input  logic [1:0]        cs_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_ce_n,
    output logic              mem_we_n,
    output logic              mem_oe_n,
    output logic [15:0]       mem_dq_out_up,
    output logic [15:0]       mem_dq_out_down,
    output logic              mem_dq_oe,
    input  logic [15:0]       mem_dq_in_up,
    input  logic [15:0]       mem_dq_in_down,
    output logic              rsp_valid,
    output logic              rsp_was_read,
    output logic [15:0]       rdata_up,
    output logic [15:0]       rdata_down,
`ifdef MEM_SEQ_ERR_CNT_EN
    output logic [7:0]        err_cnt,
`endif
    input  logic [2:0]        dec_flag
);

    typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

    localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [15:0]         wup_q, wdn_q;
    logic [1:0]          cs_q;
    logic [15:0]         rdata_up_q, rdata_down_q;
    logic                accept;
    logic                active;
    logic                strobe;
    logic                last_strobe;

    assign accept      = (state_q == StIdle) && req_valid;
    assign active      = (state_q != StIdle);
    assign strobe      = (state_q == StStrobe);
    assign last_strobe = strobe && (cnt_q == 4'd1);

    // State and strobe counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; counter loads on leaving SETUP and counts STROBE cycles down
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (req_valid) state_d = StSetup;
            end
            StSetup: begin
                state_d = StStrobe;
                cnt_d   = WaitLoad;
            end
            StStrobe: begin
                if (cnt_q == 4'd1) state_d = StHold;
                else               cnt_d   = cnt_q - 4'd1;
            end
            StHold: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Request capture at acceptance; inputs are ignored for the rest of the access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            wup_q  <= 16'h0000;
            wdn_q  <= 16'h0000;
            cs_q   <= 2'b00;
        end else if (accept) begin
            we_q   <= req_we;
            addr_q <= req_addr;
            wup_q  <= wdata_up;
            wdn_q  <= wdata_down;
            cs_q   <= cs_in;
        end
    end

    // Read data sampled on the last STROBE edge; an unselected chip reads as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_up_q   <= 16'h0000;
            rdata_down_q <= 16'h0000;
        end else if (last_strobe && !we_q) begin
            rdata_up_q   <= cs_q[1] ? mem_dq_in_up   : 16'h0000;
            rdata_down_q <= cs_q[0] ? mem_dq_in_down : 16'h0000;
        end
    end

    // SRAM control and completion outputs decoded from the current state
    always_comb begin
        req_ready       = (state_q == StIdle);
        mem_addr        = active ? addr_q : '0;
        mem_ce_n        = active ? ~cs_q : 2'b11;
        mem_we_n        = !(strobe && we_q);
        mem_oe_n        = !(strobe && !we_q);
        mem_dq_oe       = active && we_q;
        mem_dq_out_up   = mem_dq_oe ? wup_q : 16'h0000;
        mem_dq_out_down = mem_dq_oe ? wdn_q : 16'h0000;
        rsp_valid       = (state_q == StHold);
        rsp_was_read    = (state_q == StHold) && !we_q;
        rdata_up        = rdata_up_q;
        rdata_down      = rdata_down_q;
    end

`ifdef MEM_SEQ_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Saturating count of reads that completed with a decoder error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'h00;
        end else if ((state_q == StHold) && !we_q && (dec_flag != 3'b000)
                     && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'h01;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_dec_flag;
    assign unused_dec_flag = ^dec_flag;
`endif

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer. Three instances share stimulus:
// a (WAIT_CYCLES=2), b (WAIT_CYCLES=1), c (WAIT_CYCLES=15).
// Define MEM_SEQ_ERR_CNT_EN to also exercise the error counter.
module tb_mem_access_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    logic [15:0] wdata_up = 16'h0000;
    logic [15:0] wdata_down = 16'h0000;
    logic [1:0]  cs_in = 2'b00;
    logic [15:0] dq_in_up = 16'h1234;
    logic [15:0] dq_in_down = 16'hABCD;
    logic [2:0]  dec_flag = 3'b000;

    logic a_ready, a_we_n, a_oe_n, a_dq_oe, a_rv, a_rr;
    logic b_ready, b_we_n, b_oe_n, b_dq_oe, b_rv, b_rr;
    logic c_ready, c_we_n, c_oe_n, c_dq_oe, c_rv, c_rr;
    logic [15:0] a_addr, b_addr, c_addr;
    logic [1:0]  a_ce_n, b_ce_n, c_ce_n;
    logic [15:0] a_dq_up, a_dq_dn, b_dq_up, b_dq_dn, c_dq_up, c_dq_dn;
    logic [15:0] a_rd_up, a_rd_dn, b_rd_up, b_rd_dn, c_rd_up, c_rd_dn;
`ifdef MEM_SEQ_ERR_CNT_EN
    logic [7:0]  a_err, b_err, c_err;
`endif

    int checks = 0;
    int errors = 0;

    // Per-cycle capture after an accept; bit k-1 / index k is spec cycle T+k
    logic [19:0] m_we_a, m_oe_a, m_dqoe_a, m_rv_a, m_we_b, m_rv_b, m_we_c, m_rv_c;
    logic [1:0]  cap_ce_a [0:20];
    logic [15:0] cap_addr_a [0:20];
    logic [15:0] cap_dqup_a [0:20];
    logic [15:0] cap_dqdn_a [0:20];
    logic        cap_rr_a [0:20];

    always #5 clk = ~clk;

    mem_access_sequencer #(.ADDR_W(16), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(a_ready),
        .req_we(req_we), .req_addr(req_addr), .wdata_up(wdata_up), .wdata_down(wdata_down),
        .cs_in(cs_in), .mem_addr(a_addr), .mem_ce_n(a_ce_n), .mem_we_n(a_we_n),
        .mem_oe_n(a_oe_n), .mem_dq_out_up(a_dq_up), .mem_dq_out_down(a_dq_dn),
        .mem_dq_oe(a_dq_oe), .mem_dq_in_up(dq_in_up), .mem_dq_in_down(dq_in_down),
        .rsp_valid(a_rv), .rsp_was_read(a_rr), .rdata_up(a_rd_up), .rdata_down(a_rd_dn),
`ifdef MEM_SEQ_ERR_CNT_EN
        .err_cnt(a_err),
`endif
        .dec_flag(dec_flag)
    );

    mem_access_sequencer #(.ADDR_W(16), .WAIT_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(b_ready),
        .req_we(req_we), .req_addr(req_addr), .wdata_up(wdata_up), .wdata_down(wdata_down),
        .cs_in(cs_in), .mem_addr(b_addr), .mem_ce_n(b_ce_n), .mem_we_n(b_we_n),
        .mem_oe_n(b_oe_n), .mem_dq_out_up(b_dq_up), .mem_dq_out_down(b_dq_dn),
        .mem_dq_oe(b_dq_oe), .mem_dq_in_up(dq_in_up), .mem_dq_in_down(dq_in_down),
        .rsp_valid(b_rv), .rsp_was_read(b_rr), .rdata_up(b_rd_up), .rdata_down(b_rd_dn),
`ifdef MEM_SEQ_ERR_CNT_EN
        .err_cnt(b_err),
`endif
        .dec_flag(dec_flag)
    );

    mem_access_sequencer #(.ADDR_W(16), .WAIT_CYCLES(15)) dut_c (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(c_ready),
        .req_we(req_we), .req_addr(req_addr), .wdata_up(wdata_up), .wdata_down(wdata_down),
        .cs_in(cs_in), .mem_addr(c_addr), .mem_ce_n(c_ce_n), .mem_we_n(c_we_n),
        .mem_oe_n(c_oe_n), .mem_dq_out_up(c_dq_up), .mem_dq_out_down(c_dq_dn),
        .mem_dq_oe(c_dq_oe), .mem_dq_in_up(dq_in_up), .mem_dq_in_down(dq_in_down),
        .rsp_valid(c_rv), .rsp_was_read(c_rr), .rdata_up(c_rd_up), .rdata_down(c_rd_dn),
`ifdef MEM_SEQ_ERR_CNT_EN
        .err_cnt(c_err),
`endif
        .dec_flag(dec_flag)
    );

    // Present one request, let it be accepted, then scramble the inputs
    task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] wu,
                         input logic [15:0] wd, input logic [1:0] cs);
        req_we = we;
        req_addr = addr;
        wdata_up = wu;
        wdata_down = wd;
        cs_in = cs;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we = ~we;
        req_addr = 16'hFFFF;
        wdata_up = ~wu;
        wdata_down = ~wd;
        cs_in = ~cs;
    endtask

    // Record 20 cycles of outputs, sampled 1 time unit after each rising edge
    task automatic capture();
        m_we_a = '0; m_oe_a = '0; m_dqoe_a = '0; m_rv_a = '0;
        m_we_b = '0; m_rv_b = '0; m_we_c = '0; m_rv_c = '0;
        for (int k = 1; k <= 20; k++) begin
            m_we_a[k-1]   = !a_we_n;
            m_oe_a[k-1]   = !a_oe_n;
            m_dqoe_a[k-1] = a_dq_oe;
            m_rv_a[k-1]   = a_rv;
            m_we_b[k-1]   = !b_we_n;
            m_rv_b[k-1]   = b_rv;
            m_we_c[k-1]   = !c_we_n;
            m_rv_c[k-1]   = c_rv;
            cap_ce_a[k]   = a_ce_n;
            cap_addr_a[k] = a_addr;
            cap_dqup_a[k] = a_dq_up;
            cap_dqdn_a[k] = a_dq_dn;
            cap_rr_a[k]   = a_rr;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (a_ce_n !== 2'b11 || a_we_n !== 1'b1 || a_oe_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl_in_reset: ce_n=%b we_n=%b oe_n=%b, required 11 1 1",
                     a_ce_n, a_we_n, a_oe_n);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (a_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b, required 1", a_ready);
        end
        checks++;
        if (a_ce_n !== 2'b11) begin
            errors++; $display("FAIL reset_ce_n: got %b, required 11", a_ce_n);
        end
        checks++;
        if (a_we_n !== 1'b1 || a_oe_n !== 1'b1) begin
            errors++; $display("FAIL reset_we_oe: got %b %b, required 1 1", a_we_n, a_oe_n);
        end
        checks++;
        if (a_dq_oe !== 1'b0 || a_addr !== 16'h0000) begin
            errors++; $display("FAIL reset_oe_addr: got %b %h, required 0 0000", a_dq_oe, a_addr);
        end
        checks++;
        if (a_dq_up !== 16'h0000 || a_dq_dn !== 16'h0000) begin
            errors++; $display("FAIL reset_dq_out: got %h %h, required 0000 0000", a_dq_up, a_dq_dn);
        end
        checks++;
        if (a_rv !== 1'b0 || a_rr !== 1'b0) begin
            errors++; $display("FAIL reset_rsp: got %b %b, required 0 0", a_rv, a_rr);
        end
        checks++;
        if (a_rd_up !== 16'h0000 || a_rd_dn !== 16'h0000) begin
            errors++; $display("FAIL reset_rdata: got %h %h, required 0000 0000", a_rd_up, a_rd_dn);
        end
    endtask

    task automatic test_write();
        issue(1'b1, 16'h0010, 16'hA5A5, 16'h5A5A, 2'b11);
        capture();
        checks++;
        if (m_we_a !== 20'h00006) begin
            errors++; $display("FAIL write_we_n_window: got %h, required 00006", m_we_a);
        end
        checks++;
        if (m_oe_a !== 20'h00000) begin
            errors++; $display("FAIL write_oe_n_window: got %h, required 00000", m_oe_a);
        end
        checks++;
        if (m_dqoe_a !== 20'h0000F) begin
            errors++; $display("FAIL write_dq_oe_window: got %h, required 0000F", m_dqoe_a);
        end
        checks++;
        if (m_rv_a !== 20'h00008) begin
            errors++; $display("FAIL write_rsp_valid_cycle: got %h, required 00008", m_rv_a);
        end
        checks++;
        if (cap_ce_a[1] !== 2'b00 || cap_ce_a[4] !== 2'b00 || cap_ce_a[5] !== 2'b11) begin
            errors++;
            $display("FAIL write_ce_n: got %b %b %b, required 00 00 11",
                     cap_ce_a[1], cap_ce_a[4], cap_ce_a[5]);
        end
        checks++;
        if (cap_addr_a[1] !== 16'h0010 || cap_addr_a[3] !== 16'h0010) begin
            errors++;
            $display("FAIL write_addr: got %h %h, required 0010 0010", cap_addr_a[1], cap_addr_a[3]);
        end
        checks++;
        if (cap_dqup_a[2] !== 16'hA5A5 || cap_dqdn_a[3] !== 16'h5A5A) begin
            errors++;
            $display("FAIL write_dq_out: got %h %h, required A5A5 5A5A", cap_dqup_a[2], cap_dqdn_a[3]);
        end
        checks++;
        if (cap_rr_a[4] !== 1'b0) begin
            errors++; $display("FAIL write_was_read: got %b, required 0", cap_rr_a[4]);
        end
    endtask

    task automatic test_read();
        issue(1'b0, 16'h0010, 16'h0000, 16'h0000, 2'b10);
        capture();
        checks++;
        if (cap_ce_a[2] !== 2'b01) begin
            errors++; $display("FAIL read_ce_n: got %b, required 01", cap_ce_a[2]);
        end
        checks++;
        if (m_oe_a !== 20'h00006) begin
            errors++; $display("FAIL read_oe_n_window: got %h, required 00006", m_oe_a);
        end
        checks++;
        if ((m_we_a | m_dqoe_a) !== 20'h00000) begin
            errors++;
            $display("FAIL read_no_write_drive: got we %h oe %h, required 00000", m_we_a, m_dqoe_a);
        end
        checks++;
        if (m_rv_a !== 20'h00008 || cap_rr_a[4] !== 1'b1) begin
            errors++;
            $display("FAIL read_rsp: got %h was_read %b, required 00008 1", m_rv_a, cap_rr_a[4]);
        end
        checks++;
        if (a_rd_up !== 16'h1234 || a_rd_dn !== 16'h0000) begin
            errors++; $display("FAIL read_rdata: got %h %h, required 1234 0000", a_rd_up, a_rd_dn);
        end
    endtask

    task automatic test_wait_widths();
        issue(1'b1, 16'h0020, 16'h1111, 16'h2222, 2'b11);
        capture();
        checks++;
        if (m_we_b !== 20'h00002 || m_rv_b !== 20'h00004) begin
            errors++;
            $display("FAIL wait1_timing: we %h rv %h, required 00002 00004", m_we_b, m_rv_b);
        end
        checks++;
        if (m_we_c !== 20'h0FFFE || m_rv_c !== 20'h10000) begin
            errors++;
            $display("FAIL wait15_timing: we %h rv %h, required 0FFFE 10000", m_we_c, m_rv_c);
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] acc;
        logic [14:0] rdy;
        req_we = 1'b1;
        req_addr = 16'h0030;
        cs_in = 2'b11;
        req_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            acc[i] = a_ready & req_valid;
            rdy[i] = a_ready;
            @(posedge clk);
        end
        req_valid = 1'b0;
        checks++;
        if (acc !== 15'h0421) begin
            errors++; $display("FAIL b2b_accept_edges: got %h, required 0421", acc);
        end
        checks++;
        if (rdy !== 15'h0421) begin
            errors++; $display("FAIL b2b_ready_pattern: got %h, required 0421", rdy);
        end
        repeat (25) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_strobe();
        logic [7:0] rv;
        logic       rdy_after;
        issue(1'b1, 16'h0040, 16'hBEEF, 16'hCAFE, 2'b11);
        @(posedge clk);
        #1;
        checks++;
        if (a_we_n !== 1'b0) begin
            errors++; $display("FAIL mid_precondition_strobe: we_n %b, required 0", a_we_n);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_ce_n !== 2'b11 || a_we_n !== 1'b1 || a_dq_oe !== 1'b0) begin
            errors++;
            $display("FAIL mid_async_reset: ce_n %b we_n %b dq_oe %b, required 11 1 0",
                     a_ce_n, a_we_n, a_dq_oe);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rdy_after = a_ready;
        rv = '0;
        for (int i = 0; i < 8; i++) begin
            rv[i] = a_rv;
            @(posedge clk);
            #1;
        end
        checks++;
        if (rdy_after !== 1'b1) begin
            errors++; $display("FAIL mid_ready_after_release: got %b, required 1", rdy_after);
        end
        checks++;
        if (rv !== 8'h00) begin
            errors++; $display("FAIL mid_no_rsp_valid: got %h, required 00", rv);
        end
        repeat (20) @(posedge clk);
        #1;
    endtask

`ifdef MEM_SEQ_ERR_CNT_EN
    task automatic test_err_cnt();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        dec_flag = 3'b001;
        cs_in = 2'b11;
        req_we = 1'b1;
        req_valid = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        checks++;
        if (a_err !== 8'h00) begin
            errors++; $display("FAIL err_cnt_writes: got %h, required 00", a_err);
        end
        req_we = 1'b0;
        req_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        checks++;
        if (a_err !== 8'h02) begin
            errors++; $display("FAIL err_cnt_two_reads: got %h, required 02", a_err);
        end
        req_valid = 1'b1;
        repeat (1500) @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        checks++;
        if (a_err !== 8'hFF) begin
            errors++; $display("FAIL err_cnt_saturate: got %h, required FF", a_err);
        end
        dec_flag = 3'b000;
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wait_widths();
        test_back_to_back();
        test_reset_mid_strobe();
`ifdef MEM_SEQ_ERR_CNT_EN
        test_err_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_sequencer.md
MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: memory address width.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: strobe length in clocks, legal range 1..15.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have ports req_valid in 1, req_ready out 1, req_we in 1 (1=write), req_addr in ADDR_W: request handshake.
REQ-006 SHALL have ports wdata_up in 16, wdata_down in 16, cs_in in 2: encoded halves and chip selects from the ECC stage.
REQ-007 SHALL have ports mem_addr out ADDR_W, mem_ce_n out 2 ([1]=up, [0]=down), mem_we_n out 1, mem_oe_n out 1: SRAM controls.
REQ-008 SHALL have ports mem_dq_out_up out 16, mem_dq_out_down out 16, mem_dq_oe out 1, mem_dq_in_up in 16, mem_dq_in_down in 16: SRAM data.
REQ-009 SHALL have ports rsp_valid out 1, rsp_was_read out 1, rdata_up out 16, rdata_down out 16: completion toward the ECC decoder.
REQ-010 SHALL have port dec_flag in 3: decoder error flag for the completed read.

Function
REQ-011 SHALL implement FSM IDLE -> SETUP -> STROBE -> HOLD -> IDLE; no other states.
REQ-012 SHALL assert req_ready only in IDLE; a request is accepted on a rising edge with req_valid & req_ready.
REQ-013 SHALL capture req_we, req_addr, wdata_up/down, cs_in at acceptance; later input changes SHALL not affect the access.
REQ-014 SHALL spend exactly 1 cycle in SETUP, WAIT_CYCLES cycles in STROBE (down-counter), 1 cycle in HOLD.
REQ-015 SHALL drive mem_addr from the captured address in SETUP, STROBE and HOLD.
REQ-016 SHALL drive mem_ce_n[i] = !captured cs_in[i] in SETUP, STROBE and HOLD, else 2'b11.
REQ-017 SHALL assert mem_we_n low (writes) or mem_oe_n low (reads) only during STROBE.
REQ-018 SHALL, for writes, assert mem_dq_oe in SETUP, STROBE and HOLD, driving captured wdata on mem_dq_out_*.
REQ-019 SHALL, for reads, register mem_dq_in_up/down into rdata_up/down on the last STROBE cycle's edge; chip with cs_in bit 0 yields 16'h0000.
REQ-020 SHALL pulse rsp_valid for exactly the HOLD cycle, rsp_was_read = captured !req_we; rdata holds until the next read.
REQ-021 SHALL give latency: accept at edge T -> rsp_valid high in cycle T+2+WAIT_CYCLES; next accept no earlier than T+3+WAIT_CYCLES.
REQ-022 SHALL run the full sequence with cs_in=2'b00 (no chip strobed) and still complete with rsp_valid.
REQ-023 SHALL never assert mem_we_n and mem_oe_n low simultaneously.

Reset
REQ-024 SHALL, on rst_n low, immediately (asynchronously) force IDLE, req_ready=1 after release, mem_ce_n=2'b11, mem_we_n=1, mem_oe_n=1, mem_dq_oe=0, mem_addr=0, mem_dq_out_*=0, rsp_valid=0, rsp_was_read=0, rdata_*=0.
REQ-025 SHALL abort an in-flight access on reset with no rsp_valid; operation resumes from IDLE on the first edge after release.

Configuration
REQ-026 SHALL, with macro MEM_SEQ_ERR_CNT_EN defined, add output err_cnt (8 bits, reset 0) incrementing by 1 in each HOLD cycle of a read where dec_flag != 0, saturating at 8'hFF.
REQ-027 SHALL, without MEM_SEQ_ERR_CNT_EN, omit err_cnt entirely; dec_flag is then unused and all other behaviour is identical.

Verification
REQ-028 SHALL cover write: WAIT_CYCLES=2, addr 16'h0010, wdata 16'hA5A5/16'h5A5A, cs_in 11 -> mem_we_n low 2 cycles, mem_ce_n=00, dq_oe 4 cycles, rsp_valid in cycle T+4, rsp_was_read=0.
REQ-029 SHALL cover read: addr 16'h0010, SRAM returns 16'h1234/16'hABCD, cs_in 10 -> mem_ce_n=01, rdata_up=16'h1234, rdata_down=16'h0000, rsp_valid at T+4.
REQ-030 SHALL cover back-to-back: req_valid held high with two requests -> req_ready low in SETUP..HOLD, second accept exactly 5 cycles after the first.
REQ-031 SHALL cover reset mid-STROBE: rst_n low for 1 cycle -> mem_ce_n=11, mem_we_n=1 same cycle, no rsp_valid, req_ready=1 after release.
REQ-032 SHALL cover WAIT_CYCLES=1 and 15 -> strobe width 1 and 15 cycles, rsp_valid at T+3 and T+17.
REQ-033 SHALL cover, with MEM_SEQ_ERR_CNT_EN, 300 reads with dec_flag=3'b001 -> err_cnt saturates at 8'hFF; writes never increment it.
